// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and the operation encoding for paged_program_counter.
package pc_pkg;

    localparam int unsigned PC_AW = 10;
    localparam int unsigned PC_PW = 2;
    localparam int unsigned PC_SD = 4;

    // Winning request for the current cycle, produced by the priority encoder
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_BRANCH,
        OP_CALL,
        OP_RET,
        OP_LJUMP,
        OP_INC
    } pc_op_e;

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: small LIFO holding subroutine return addresses.
// A push while full and a pop while empty are ignored; the caller flags them.
module pc_return_stack #(
    parameter int unsigned AW = 10,
    parameter int unsigned SD = 4
) (
    input  logic          clk,
    input  logic          start_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int unsigned IW = $clog2(SD);
    localparam int unsigned CW = IW + 1;

    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_mem [SD];
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_cnt == CW'(SD));
    assign empty     = (r_cnt == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    // Count doubles as write pointer; the newest entry sits one below it
    assign w_wr_idx  = r_cnt[IW-1:0];
    assign w_top_idx = w_wr_idx - IW'(1);
    assign top       = r_mem[w_top_idx];

    // Entry count: reset to empty, push and pop never coincide
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            r_cnt <= '0;
        end else if (w_push_ok) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (w_pop_ok) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Storage has no reset; contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/paged_program_counter.sv
// paged_program_counter: paged PC with in-page increment/branch, long jump
// and subroutine call/return.
// Define PC_RETURN_STACK_EN to build the return stack; otherwise call is a
// plain jump, ret increments and the stack status outputs are constants.
module paged_program_counter
    import pc_pkg::*;
#(
    parameter int unsigned   AW         = PC_AW,
    parameter int unsigned   PW         = PC_PW,
    parameter int unsigned   SD         = PC_SD,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic             clk,
    input  logic             start_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             br_taken,
    input  logic [AW-PW-1:0] br_target,
    input  logic             ljump,
    input  logic [PW-1:0]    lj_page,
    input  logic [AW-PW-1:0] lj_offset,
    input  logic             call,
    input  logic [AW-1:0]    sub_addr,
    input  logic             ret,
    input  logic             clr_err,
    output logic [AW-1:0]    rp,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_ovf,
    output logic             stk_unf
);

    localparam int unsigned OW = AW - PW;

    pc_op_e        w_op;
    logic [AW-1:0] r_rp;
    logic [AW-1:0] w_rp_next;
    logic [AW-1:0] w_inc;
    logic          w_full;
    logic          w_empty;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic          r_ovf;
    logic          r_unf;

    // Increment wraps inside the current page
    assign w_inc = {r_rp[AW-1:OW], r_rp[OW-1:0] + OW'(1)};

`ifdef PC_RETURN_STACK_EN
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_ret_addr;
    logic          w_push;
    logic          w_pop;

    // Return address is full width so a call at a page end returns to the next page
    assign w_ret_addr = r_rp + AW'(1);
    assign w_push     = (w_op == OP_CALL) && !w_full;
    assign w_pop      = (w_op == OP_RET);
    assign w_ovf_set  = (w_op == OP_CALL) && w_full;
    assign w_unf_set  = !stall && !branch && !call && ret && w_empty;

    pc_return_stack #(
        .AW(AW),
        .SD(SD)
    ) u_stack (
        .clk    (clk),
        .start_n(start_n),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_ret_addr),
        .top    (w_top),
        .full   (w_full),
        .empty  (w_empty)
    );
`else
    assign w_full    = 1'b0;
    assign w_empty   = 1'b1;
    assign w_ovf_set = 1'b0;
    assign w_unf_set = 1'b0;
`endif

    // Priority encode: stall > branch > call > ret > ljump > increment
    always_comb begin
        w_op = OP_INC;
        if (stall) begin
            w_op = OP_HOLD;
        end else if (branch) begin
            w_op = br_taken ? OP_BRANCH : OP_INC;
        end else if (call) begin
            w_op = OP_CALL;
        end else if (ret) begin
            w_op = w_empty ? OP_INC : OP_RET;
        end else if (ljump) begin
            w_op = OP_LJUMP;
        end
    end

    // Next program counter for the selected operation
    always_comb begin
        w_rp_next = w_inc;
        unique case (w_op)
            OP_HOLD:   w_rp_next = r_rp;
            OP_BRANCH: w_rp_next = {r_rp[AW-1:OW], br_target};
            OP_CALL:   w_rp_next = sub_addr;
`ifdef PC_RETURN_STACK_EN
            OP_RET:    w_rp_next = w_top;
`endif
            OP_LJUMP:  w_rp_next = {lj_page, lj_offset};
            default:   w_rp_next = w_inc;
        endcase
    end

    // Program counter register
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            r_rp <= START_ADDR;
        end else begin
            r_rp <= w_rp_next;
        end
    end

    // Sticky error flags; a fresh error beats clr_err, stall freezes both
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!stall) begin
            r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
            r_unf <= w_unf_set | (r_unf & ~clr_err);
        end
    end

    assign rp        = r_rp;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;
    assign stk_ovf   = r_ovf;
    assign stk_unf   = r_unf;

endmodule

// File: tb/tb_paged_program_counter.sv
// tb_paged_program_counter: directed vectors with a scoreboard queue.
// Expectations cover both builds (PC_RETURN_STACK_EN defined or not).
module tb_paged_program_counter;

    localparam int unsigned AW = 10;
    localparam int unsigned PW = 2;
    localparam int unsigned SD = 4;
    localparam int unsigned OW = AW - PW;
`ifdef PC_RETURN_STACK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] rp;
        logic          emp;
        logic          ful;
        logic          ovf;
        logic          unf;
    } exp_t;

    logic          clk = 1'b0;
    logic          start_n = 1'b1;
    logic          stall;
    logic          branch;
    logic          br_taken;
    logic [OW-1:0] br_target;
    logic          ljump;
    logic [PW-1:0] lj_page;
    logic [OW-1:0] lj_offset;
    logic          call;
    logic [AW-1:0] sub_addr;
    logic          ret;
    logic          clr_err;
    logic [AW-1:0] rp;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_ovf;
    logic          stk_unf;

    int   checks = 0;
    int   errors = 0;
    int   mon_n = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    paged_program_counter #(
        .AW        (AW),
        .PW        (PW),
        .SD        (SD),
        .START_ADDR(10'h000)
    ) dut (
        .clk      (clk),
        .start_n  (start_n),
        .stall    (stall),
        .branch   (branch),
        .br_taken (br_taken),
        .br_target(br_target),
        .ljump    (ljump),
        .lj_page  (lj_page),
        .lj_offset(lj_offset),
        .call     (call),
        .sub_addr (sub_addr),
        .ret      (ret),
        .clr_err  (clr_err),
        .rp       (rp),
        .stk_full (stk_full),
        .stk_empty(stk_empty),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf)
    );

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Without the stack the status outputs are constant: empty=1, others 0
    function automatic exp_t e(input logic [AW-1:0] r, input logic emp, input logic ful,
                               input logic ovf, input logic unf);
        exp_t x;
        x.rp  = r;
        x.emp = EN ? emp : 1'b1;
        x.ful = EN ? ful : 1'b0;
        x.ovf = EN ? ovf : 1'b0;
        x.unf = EN ? unf : 1'b0;
        return x;
    endfunction

    task automatic idle();
        stall     = 1'b0;
        branch    = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        ljump     = 1'b0;
        lj_page   = '0;
        lj_offset = '0;
        call      = 1'b0;
        sub_addr  = '0;
        ret       = 1'b0;
        clr_err   = 1'b0;
    endtask

    // Inputs are already set; queue the expected post-edge state, advance one cycle
    task automatic cyc(input exp_t x);
        q.push_back(x);
        @(negedge clk);
        idle();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rp"}, rp, 10'h000);
        chk({tag, "_empty"}, {9'b0, stk_empty}, 10'd1);
        chk({tag, "_full"}, {9'b0, stk_full}, 10'd0);
        chk({tag, "_ovf"}, {9'b0, stk_ovf}, 10'd0);
        chk({tag, "_unf"}, {9'b0, stk_unf}, 10'd0);
    endtask

    // Monitor: every active edge with a queued expectation is compared
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_n++;
            chk($sformatf("rp@%0d", mon_n), rp, mon_e.rp);
            chk($sformatf("empty@%0d", mon_n), {9'b0, stk_empty}, {9'b0, mon_e.emp});
            chk($sformatf("full@%0d", mon_n), {9'b0, stk_full}, {9'b0, mon_e.ful});
            chk($sformatf("ovf@%0d", mon_n), {9'b0, stk_ovf}, {9'b0, mon_e.ovf});
            chk($sformatf("unf@%0d", mon_n), {9'b0, stk_unf}, {9'b0, mon_e.unf});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #3 start_n = 1'b0;
        #1 reset_checks("reset");
        @(negedge clk);
        start_n = 1'b1;

        // Idle increments after release
        cyc(e(10'h001, 1, 0, 0, 0));
        cyc(e(10'h002, 1, 0, 0, 0));
        cyc(e(10'h003, 1, 0, 0, 0));

        // Page wrap and in-page branch
        ljump = 1; lj_page = 2'd2; lj_offset = 8'hFF;
        cyc(e(10'h2FF, 1, 0, 0, 0));
        cyc(e(10'h200, 1, 0, 0, 0));
        ljump = 1; lj_page = 2'd1; lj_offset = 8'h55;
        cyc(e(10'h155, 1, 0, 0, 0));
        branch = 1; br_taken = 1; br_target = 8'h40;
        cyc(e(10'h140, 1, 0, 0, 0));
        branch = 1; br_taken = 0; br_target = 8'h77;
        cyc(e(10'h141, 1, 0, 0, 0));

        // Nested call / return
        ljump = 1; lj_page = 2'd0; lj_offset = 8'h10;
        cyc(e(10'h010, 1, 0, 0, 0));
        call = 1; sub_addr = 10'h300;
        cyc(e(10'h300, 0, 0, 0, 0));
        call = 1; sub_addr = 10'h380;
        cyc(e(10'h380, 0, 0, 0, 0));
        ret = 1;
        cyc(e(EN ? 10'h301 : 10'h381, 0, 0, 0, 0));
        ret = 1;
        cyc(e(EN ? 10'h011 : 10'h382, 1, 0, 0, 0));

        // Overflow, LIFO order, underflow, clear
        ljump = 1; lj_page = 2'd0; lj_offset = 8'h20;
        cyc(e(10'h020, 1, 0, 0, 0));
        call = 1; sub_addr = 10'h100; cyc(e(10'h100, 0, 0, 0, 0));
        call = 1; sub_addr = 10'h110; cyc(e(10'h110, 0, 0, 0, 0));
        call = 1; sub_addr = 10'h120; cyc(e(10'h120, 0, 0, 0, 0));
        call = 1; sub_addr = 10'h130; cyc(e(10'h130, 0, 1, 0, 0));
        call = 1; sub_addr = 10'h140; cyc(e(10'h140, 0, 1, 1, 0));
        ret = 1; cyc(e(EN ? 10'h121 : 10'h141, 0, 0, 1, 0));
        ret = 1; cyc(e(EN ? 10'h111 : 10'h142, 0, 0, 1, 0));
        ret = 1; cyc(e(EN ? 10'h101 : 10'h143, 0, 0, 1, 0));
        ret = 1; cyc(e(EN ? 10'h021 : 10'h144, 1, 0, 1, 0));
        ret = 1; cyc(e(EN ? 10'h022 : 10'h145, 1, 0, 1, 1));
        clr_err = 1; cyc(e(EN ? 10'h023 : 10'h146, 1, 0, 0, 0));
        clr_err = 1; ret = 1; cyc(e(EN ? 10'h024 : 10'h147, 1, 0, 0, 1));
        clr_err = 1; cyc(e(EN ? 10'h025 : 10'h148, 1, 0, 0, 0));

        // Priority and stall
        ljump = 1; lj_page = 2'd1; lj_offset = 8'h00;
        cyc(e(10'h100, 1, 0, 0, 0));
        branch = 1; br_taken = 1; br_target = 8'h33;
        call = 1; sub_addr = 10'h3AA; ret = 1;
        ljump = 1; lj_page = 2'd3; lj_offset = 8'h11;
        cyc(e(10'h133, 1, 0, 0, 0));
        stall = 1; call = 1; sub_addr = 10'h2AA;
        cyc(e(10'h133, 1, 0, 0, 0));
        cyc(e(10'h134, 1, 0, 0, 0));
        call = 1; sub_addr = 10'h200;
        cyc(e(10'h200, 0, 0, 0, 0));
        stall = 1; call = 1; sub_addr = 10'h2BB;
        cyc(e(10'h200, 0, 0, 0, 0));
        ret = 1;
        cyc(e(EN ? 10'h135 : 10'h201, 1, 0, 0, 0));

        // Asynchronous reset in the middle of a call
        call = 1; sub_addr = 10'h2C0;
        cyc(e(10'h2C0, 0, 0, 0, 0));
        call = 1; sub_addr = 10'h3F0;
        #2 start_n = 1'b0;
        #1 reset_checks("midcall");
        @(negedge clk);
        idle();
        start_n = 1'b1;
        call = 1; sub_addr = 10'h0AB;
        cyc(e(10'h0AB, 0, 0, 0, 0));
        ret = 1;
        cyc(e(EN ? 10'h001 : 10'h0AC, 1, 0, 0, 0));

        // Every queued expectation must have been consumed
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drain", AW'(q.size()), 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
